// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parametrised FIFO with count, almost flags, sticky errors and flush
// Optional first-word-fall-through read port selected by SYNC_FIFO_FWFT_EN.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 5,
    parameter int AF_THRESH = 28,
    parameter int AE_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wd_en,
    input  logic [DATA_W-1:0] d_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] d_out,
    output logic              w_en,
    output logic              r_en,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int             DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AF_C = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_C = (ADDR_W + 1)'(AE_THRESH);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   w_ptr_q, w_ptr_d;
    logic [ADDR_W:0]   r_ptr_q, r_ptr_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              do_wr, do_rd;

    // Status is purely a function of the registered pointers.
    assign full         = (w_ptr_q[ADDR_W] != r_ptr_q[ADDR_W]) &&
                          (w_ptr_q[ADDR_W-1:0] == r_ptr_q[ADDR_W-1:0]);
    assign empty        = (w_ptr_q == r_ptr_q);
    assign count        = w_ptr_q - r_ptr_q;
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    assign w_en  = wd_en & ~full;
    assign r_en  = rd_en & ~empty;
    // Flush wins over any request in the same cycle.
    assign do_wr = w_en & ~flush;
    assign do_rd = r_en & ~flush;

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (do_wr)         w_ptr_d = w_ptr_q + ONE;
            if (do_rd)         r_ptr_d = r_ptr_q + ONE;
            if (wd_en && full) ovf_d   = 1'b1;
            if (rd_en && empty) udf_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[w_ptr_q[ADDR_W-1:0]] <= d_in;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign d_out = mem_q[r_ptr_q[ADDR_W-1:0]];
`else
    logic [DATA_W-1:0] d_out_q, d_out_d;

    always_comb begin
        d_out_d = d_out_q;
        if (flush)      d_out_d = '0;
        else if (do_rd) d_out_d = mem_q[r_ptr_q[ADDR_W-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_out_q <= '0;
        else        d_out_q <= d_out_d;
    end

    assign d_out = d_out_q;
`endif

endmodule
